writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Shares the single register-file write port, and the rstatus write port, between the pipeline's W stage and the multicycle multiply/divide unit. Multdiv results are queued in a small FIFO and drained when the W stage is idle, when the FIFO fills, or when an aging guard forces them through. The block drives the register-file write controls directly. It also exposes a stall to the pipeline and a pending-destination lookup for the decoder's hazard logic.

## Interface

Parameters:
- DEPTH, 2: multdiv result FIFO entries; must be 2 or more.
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may lose arbitration before it is forced to win.

Ports:
- Clocking (already decided): one clock, `clock`; reset `reset_n` is asynchronous and active-low.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- w_valid  in  1  W stage requests a regfile write this cycle.
- w_rd  in  5  W stage destination register.
- w_data  in  32  W stage write data.
- w_status_valid  in  1  W stage also writes rstatus.
- w_status_data  in  32  W stage rstatus value.
- md_valid  in  1  multdiv result offered; push occurs when md_valid=1 and md_ready=1.
- md_rd  in  5  multdiv destination register.
- md_data  in  32  multdiv result.
- md_exception  in  1  multdiv overflow or divide-by-zero.
- md_ready  out  1  FIFO can accept a result.
- stall_w  out  1  W request was not granted; W must hold its inputs next cycle.
- q_rd  in  5  decoder hazard query register.
- q_hit  out  1  a buffered entry targets q_rd.
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  5  regfile write address.
- data_writeReg  out  32  regfile write data.
- ctrl_writeStatus  out  1  rstatus write enable.
- data_writeStatusReg  out  32  rstatus write data.

## Operation

- FIFO: DEPTH entries, each holding {rd, data, exception}. Pointers wrap modulo DEPTH. The count register holds values 0..DEPTH.
- md_ready = (count != DEPTH). This is derived from registered state only. There is no push-when-full, even if the FIFO is popped in the same cycle.
- Arbitration (combinational, per cycle). The FIFO head is granted (md_grant) when count>0 AND any of the following holds:
  - w_valid=0;
  - count==DEPTH;
  - force_md=1.
- Otherwise, if w_valid=1, W is granted (w_grant).
- stall_w = w_valid & ~w_grant.
- A granted W request copies w_rd and w_data to the write port. ctrl_writeStatus = w_status_valid, with data w_status_data.
- A granted md entry pops the FIFO and copies rd and data to the write port. ctrl_writeStatus = exception, with data_writeStatusReg = {31'b0, exception}.
- A grant with rd=0 drives ctrl_writeEnable=0. The grant still consumes the slot, and the status write still occurs.
- Push and pop in the same cycle leaves count unchanged. A push into an empty FIFO is not eligible for grant until the next cycle.
- q_hit = 1 if any valid entry has rd==q_rd and q_rd!=0. The query covers stored entries only, not the incoming push.
- Ordering: the decoder uses q_hit to stall any younger instruction writing the same rd. The arbiter does not reorder or merge writes.

## Timing

- Write-port outputs are registered. A grant in cycle N appears on ctrl_*/data_* during cycle N+1 only. With no grant, both enables are 0 in N+1; data outputs hold their last value.
- md_ready, stall_w and q_hit are combinational from current state and inputs.
- Minimum latency is 2 cycles: push in N, grant in N+1, regfile write visible in N+2.
- Reset (asynchronous, any time) sets:
  - count=0, both pointers=0, age=0;
  - ctrl_writeEnable=0, ctrl_writeStatus=0;
  - ctrl_writeReg=0, data_writeReg=0, data_writeStatusReg=0.
- Reset flushes any buffered entries. After reset, md_ready=1, q_hit=0, and stall_w=0.

## Configuration

- WB_STARVE_GUARD_EN defined:
  - An age counter, width $clog2(STARVE_LIMIT+1), increments each cycle that count>0 and W wins.
  - It clears on any md_grant and whenever count==0.
  - force_md = (age==STARVE_LIMIT).
- WB_STARVE_GUARD_EN undefined: no age counter and force_md=0. The FIFO drains only when W is idle or the FIFO is full.

## Test plan

- Reset mid-drain: FIFO holds 2 entries, assert reset_n=0 → count=0, md_ready=1, both enables 0 immediately; no writes after release.
- Idle drain: md push rd=5 data=0x1234 while w_valid=0 → two cycles later ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0x1234, ctrl_writeStatus=0.
- Full preemption (DEPTH=2): FIFO full with w_valid=1 rd=3 → stall_w=1 for one cycle and the md head is written. Next cycle W is written, rd=3.
- Exception and r0: md push rd=0 with md_exception=1 → ctrl_writeEnable=0, ctrl_writeStatus=1, data_writeStatusReg=0x00000001.
- Starvation (guard on, STARVE_LIMIT=4): one entry buffered with w_valid held at 1 → W wins for 4 cycles, the 5th cycle grants md with stall_w=1. With guard off, the entry stays buffered until w_valid=0.
- Hazard query: buffer rd=7, q_rd=7 → q_hit=1; q_rd=0 → q_hit=0; after the drain grant → q_hit=0.

Source files
------------

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Shares the register-file write port and the rstatus write port
//            between the W pipeline stage and the multicycle multiply/divide
//            unit. Multdiv results queue in a DEPTH-entry FIFO and drain when
//            W is idle, when the FIFO is full, or (optional) when an aging
//            guard forces them through.
// Ports    : clock, reset_n (async, active-low)
//            w_*   : W stage write request (rd, data, optional rstatus write)
//            md_*  : multdiv result push (valid/ready handshake)
//            stall_w : W request lost arbitration this cycle
//            q_rd / q_hit : decoder hazard lookup over buffered entries
//            ctrl_* / data_* : registered regfile / rstatus write controls
// Config   : `define WB_STARVE_GUARD_EN enables the starvation age counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        w_valid,
    input  logic [4:0]  w_rd,
    input  logic [31:0] w_data,
    input  logic        w_status_valid,
    input  logic [31:0] w_status_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        md_exception,
    output logic        md_ready,
    output logic        stall_w,
    input  logic [4:0]  q_rd,
    output logic        q_hit,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        ctrl_writeStatus,
    output logic [31:0] data_writeStatusReg
);

    localparam int              c_PW       = $clog2(DEPTH);
    localparam int              c_CW       = $clog2(DEPTH + 1);
    localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);

    logic [4:0]       r_rd_mem  [DEPTH];
    logic [31:0]      r_data_mem[DEPTH];
    logic             r_exc_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_push;
    logic w_md_grant;
    logic w_w_grant;
    logic w_force_md;
    logic w_empty;
    logic w_full;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL);
    assign md_ready   = ~w_full;
    assign w_push     = md_valid & md_ready;

    // A fresh push is not visible to arbitration: grant looks only at r_count.
    assign w_md_grant = ~w_empty & (~w_valid | w_full | w_force_md);
    assign w_w_grant  = w_valid & ~w_md_grant;
    assign stall_w    = w_valid & ~w_w_grant;

`ifdef WB_STARVE_GUARD_EN
    localparam int c_AW = $clog2(STARVE_LIMIT + 1);

    logic [c_AW-1:0] r_age;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_age <= '0;
        end else if (w_md_grant || w_empty) begin
            r_age <= '0;
        end else if (w_w_grant) begin
            r_age <= r_age + 1'b1;
        end
    end

    assign w_force_md = (r_age == c_AW'(STARVE_LIMIT));
`else
    // No guard: the head is never forced (the limit only matters with the guard).
    assign w_force_md = (STARVE_LIMIT < 0);
`endif

    // Entry storage carries no reset; r_valid/r_count define what is live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_rd_mem[r_wr_ptr]   <= md_rd;
            r_data_mem[r_wr_ptr] <= md_data;
            r_exc_mem[r_wr_ptr]  <= md_exception;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_md_grant) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            // The pushed slot can never be the popped slot: push needs a
            // non-full FIFO and pop a non-empty one, so pointers differ or
            // the FIFO is empty (no pop).
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == c_PW'(i))) begin
                    r_valid[i] <= 1'b1;
                end else if (w_md_grant && (r_rd_ptr == c_PW'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
            case ({w_push, w_md_grant})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_rd_mem[i] == q_rd) && (q_rd != 5'd0)) begin
                q_hit = 1'b1;
            end
        end
    end

    // Registered write port: enables pulse for exactly one cycle per grant,
    // data holds its last value between grants.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_writeEnable    <= 1'b0;
            ctrl_writeReg       <= 5'd0;
            data_writeReg       <= 32'd0;
            ctrl_writeStatus    <= 1'b0;
            data_writeStatusReg <= 32'd0;
        end else if (w_md_grant) begin
            ctrl_writeEnable    <= (r_rd_mem[r_rd_ptr] != 5'd0);
            ctrl_writeReg       <= r_rd_mem[r_rd_ptr];
            data_writeReg       <= r_data_mem[r_rd_ptr];
            ctrl_writeStatus    <= r_exc_mem[r_rd_ptr];
            data_writeStatusReg <= {31'd0, r_exc_mem[r_rd_ptr]};
        end else if (w_w_grant) begin
            ctrl_writeEnable    <= (w_rd != 5'd0);
            ctrl_writeReg       <= w_rd;
            data_writeReg       <= w_data;
            ctrl_writeStatus    <= w_status_valid;
            data_writeStatusReg <= w_status_data;
        end else begin
            ctrl_writeEnable    <= 1'b0;
            ctrl_writeStatus    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_arbiter
// Purpose  : Directed self-checking bench for writeback_arbiter (DEPTH=2,
//            STARVE_LIMIT=4). Inputs change on the falling edge; combinational
//            outputs are checked before the rising edge, registered outputs
//            1 time unit after it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    logic        clock;
    logic        reset_n;
    logic        w_valid;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        w_status_valid;
    logic [31:0] w_status_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_exception;
    logic        md_ready;
    logic        stall_w;
    logic [4:0]  q_rd;
    logic        q_hit;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        ctrl_writeStatus;
    logic [31:0] data_writeStatusReg;

    int tests;
    int fails;

    writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .w_valid             (w_valid),
        .w_rd                (w_rd),
        .w_data              (w_data),
        .w_status_valid      (w_status_valid),
        .w_status_data       (w_status_data),
        .md_valid            (md_valid),
        .md_rd               (md_rd),
        .md_data             (md_data),
        .md_exception        (md_exception),
        .md_ready            (md_ready),
        .stall_w             (stall_w),
        .q_rd                (q_rd),
        .q_hit               (q_hit),
        .ctrl_writeEnable    (ctrl_writeEnable),
        .ctrl_writeReg       (ctrl_writeReg),
        .data_writeReg       (data_writeReg),
        .ctrl_writeStatus    (ctrl_writeStatus),
        .data_writeStatusReg (data_writeStatusReg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_inputs();
        w_valid = 0; w_rd = 0; w_data = 0; w_status_valid = 0; w_status_data = 0;
        md_valid = 0; md_rd = 0; md_data = 0; md_exception = 0; q_rd = 0;
    endtask

    task automatic rise();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        #3;
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL rst_we got %b want 0", ctrl_writeEnable); end
        tests++; if (ctrl_writeStatus !== 1'b0) begin fails++; $display("FAIL rst_ws got %b want 0", ctrl_writeStatus); end
        tests++; if (ctrl_writeReg !== 5'd0) begin fails++; $display("FAIL rst_wreg got %0d want 0", ctrl_writeReg); end
        tests++; if (data_writeReg !== 32'd0) begin fails++; $display("FAIL rst_wdata got %h want 0", data_writeReg); end
        tests++; if (data_writeStatusReg !== 32'd0) begin fails++; $display("FAIL rst_sdata got %h want 0", data_writeStatusReg); end
        tests++; if (md_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", md_ready); end
        tests++; if (q_hit !== 1'b0 || stall_w !== 1'b0) begin fails++; $display("FAIL rst_hit_stall got %b%b want 00", q_hit, stall_w); end
        @(negedge clock); @(negedge clock);
        reset_n = 1;
    endtask

    task automatic test_idle_drain();
        @(negedge clock);
        md_valid = 1; md_rd = 5'd5; md_data = 32'h1234; md_exception = 0;
        #1;
        tests++; if (md_ready !== 1'b1) begin fails++; $display("FAIL idle_ready got %b want 1", md_ready); end
        rise();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL idle_early_we got %b want 0", ctrl_writeEnable); end
        @(negedge clock);
        md_valid = 0;
        rise();
        tests++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_writeStatus} !== {1'b1, 5'd5, 32'h1234, 1'b0})
            begin fails++; $display("FAIL idle_write got we=%b rd=%0d d=%h ws=%b want 1/5/1234/0", ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_writeStatus); end
        rise();
        tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL idle_pulse got %b want 0", ctrl_writeEnable); end
    endtask

    task automatic test_full_preempt();
        @(negedge clock);
        w_valid = 1; w_rd = 5'd9; w_data = 32'hA; md_valid = 1; md_rd = 5'd10; md_data = 32'hB;
        rise();
        tests++; if (ctrl_writeReg !== 5'd9 || ctrl_writeEnable !== 1'b1) begin fails++; $display("FAIL pre_w1 got rd=%0d we=%b want 9/1", ctrl_writeReg, ctrl_writeEnable); end
        @(negedge clock);
        w_rd = 5'd11; w_data = 32'hC; md_rd = 5'd12; md_data = 32'hD;
        #1;
        tests++; if (stall_w !== 1'b0) begin fails++; $display("FAIL pre_nostall got %b want 0", stall_w); end
        rise();
        tests++; if (ctrl_writeReg !== 5'd11) begin fails++; $display("FAIL pre_w2 got %0d want 11", ctrl_writeReg); end
        @(negedge clock);
        md_valid = 0; w_rd = 5'd3; w_data = 32'h33;
        #1;
        tests++; if (md_ready !== 1'b0) begin fails++; $display("FAIL pre_full_ready got %b want 0", md_ready); end
        tests++; if (stall_w !== 1'b1) begin fails++; $display("FAIL pre_stall got %b want 1", stall_w); end
        rise();
        tests++; if (ctrl_writeReg !== 5'd10 || data_writeReg !== 32'hB) begin fails++; $display("FAIL pre_md_head got rd=%0d d=%h want 10/b", ctrl_writeReg, data_writeReg); end
        @(negedge clock); #1;
        tests++; if (stall_w !== 1'b0) begin fails++; $display("FAIL pre_release got %b want 0", stall_w); end
        rise();
        tests++; if (ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h33 || ctrl_writeEnable !== 1'b1) begin fails++; $display("FAIL pre_w3 got rd=%0d d=%h want 3/33", ctrl_writeReg, data_writeReg); end
        @(negedge clock);
        w_valid = 0;
        rise();
        tests++; if (ctrl_writeReg !== 5'd12 || data_writeReg !== 32'hD) begin fails++; $display("FAIL pre_md_tail got rd=%0d d=%h want 12/d", ctrl_writeReg, data_writeReg); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_exception_r0();
        @(negedge clock);
        md_valid = 1; md_rd = 5'd0; md_data = 32'hDEAD; md_exception = 1;
        rise();
        tests++; if (ctrl_writeStatus !== 1'b0) begin fails++; $display("FAIL exc_early got %b want 0", ctrl_writeStatus); end
        @(negedge clock);
        idle_inputs();
        rise();
        tests++; if ({ctrl_writeEnable, ctrl_writeStatus, data_writeStatusReg} !== {1'b0, 1'b1, 32'h1})
            begin fails++; $display("FAIL exc_r0 got we=%b ws=%b sd=%h want 0/1/00000001", ctrl_writeEnable, ctrl_writeStatus, data_writeStatusReg); end
    endtask

    task automatic test_w_status();
        @(negedge clock);
        w_valid = 1; w_rd = 5'd4; w_data = 32'h44; w_status_valid = 1; w_status_data = 32'hCAFE;
        rise();
        tests++; if ({ctrl_writeEnable, ctrl_writeStatus, data_writeStatusReg} !== {1'b1, 1'b1, 32'hCAFE})
            begin fails++; $display("FAIL w_status got we=%b ws=%b sd=%h want 1/1/cafe", ctrl_writeEnable, ctrl_writeStatus, data_writeStatusReg); end
        @(negedge clock);
        idle_inputs();
        rise();
        tests++; if (ctrl_writeStatus !== 1'b0 || data_writeReg !== 32'h44) begin fails++; $display("FAIL w_hold got ws=%b d=%h want 0/44", ctrl_writeStatus, data_writeReg); end
    endtask

    task automatic test_hazard();
        @(negedge clock);
        w_valid = 1; w_rd = 5'd20; w_data = 32'h20; md_valid = 1; md_rd = 5'd7; md_data = 32'h77; q_rd = 5'd7;
        #1;
        tests++; if (q_hit !== 1'b0) begin fails++; $display("FAIL hz_push got %b want 0", q_hit); end
        rise();
        @(negedge clock);
        md_valid = 0;
        #1;
        tests++; if (q_hit !== 1'b1) begin fails++; $display("FAIL hz_hit got %b want 1", q_hit); end
        q_rd = 5'd0; #1;
        tests++; if (q_hit !== 1'b0) begin fails++; $display("FAIL hz_r0 got %b want 0", q_hit); end
        q_rd = 5'd8; #1;
        tests++; if (q_hit !== 1'b0) begin fails++; $display("FAIL hz_other got %b want 0", q_hit); end
        q_rd = 5'd7; w_valid = 0;
        rise();
        tests++; if (ctrl_writeReg !== 5'd7 || data_writeReg !== 32'h77) begin fails++; $display("FAIL hz_drain got rd=%0d d=%h want 7/77", ctrl_writeReg, data_writeReg); end
        @(negedge clock); #1;
        tests++; if (q_hit !== 1'b0) begin fails++; $display("FAIL hz_after got %b want 0", q_hit); end
        idle_inputs();
    endtask

    task automatic test_starvation();
        @(negedge clock);
        w_valid = 1; w_rd = 5'd21; w_data = 32'h21; md_valid = 1; md_rd = 5'd13; md_data = 32'h13;
        rise();
        @(negedge clock);
        md_valid = 0;
`ifdef WB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (stall_w !== 1'b0) begin fails++; $display("FAIL st_win%0d got %b want 0", i, stall_w); end
            rise();
            tests++; if (ctrl_writeReg !== 5'd21) begin fails++; $display("FAIL st_wreg%0d got %0d want 21", i, ctrl_writeReg); end
            @(negedge clock);
        end
        #1;
        tests++; if (stall_w !== 1'b1) begin fails++; $display("FAIL st_force got %b want 1", stall_w); end
        rise();
        tests++; if (ctrl_writeReg !== 5'd13) begin fails++; $display("FAIL st_md got %0d want 13", ctrl_writeReg); end
`else
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++; if (stall_w !== 1'b0) begin fails++; $display("FAIL st_win%0d got %b want 0", i, stall_w); end
            rise();
            tests++; if (ctrl_writeReg !== 5'd21) begin fails++; $display("FAIL st_wreg%0d got %0d want 21", i, ctrl_writeReg); end
            @(negedge clock);
        end
        w_valid = 0;
        rise();
        tests++; if (ctrl_writeReg !== 5'd13 || data_writeReg !== 32'h13) begin fails++; $display("FAIL st_md got rd=%0d d=%h want 13/13", ctrl_writeReg, data_writeReg); end
`endif
        @(negedge clock);
        idle_inputs();
        rise();
    endtask

    task automatic test_reset_mid_drain();
        @(negedge clock);
        w_valid = 1; w_rd = 5'd1; md_valid = 1; md_rd = 5'd14; md_data = 32'hE;
        rise();
        @(negedge clock);
        md_rd = 5'd15; md_data = 32'hF;
        rise();
        @(negedge clock);
        idle_inputs();
        rise();
        tests++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd14) begin fails++; $display("FAIL rm_first got we=%b rd=%0d want 1/14", ctrl_writeEnable, ctrl_writeReg); end
        #1;
        reset_n = 0; q_rd = 5'd15;
        #1;
        tests++; if (ctrl_writeEnable !== 1'b0 || ctrl_writeStatus !== 1'b0) begin fails++; $display("FAIL rm_en got we=%b ws=%b want 0/0", ctrl_writeEnable, ctrl_writeStatus); end
        tests++; if (md_ready !== 1'b1 || q_hit !== 1'b0) begin fails++; $display("FAIL rm_state got rdy=%b hit=%b want 1/0", md_ready, q_hit); end
        @(negedge clock); @(negedge clock);
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            rise();
            tests++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL rm_post%0d got %b want 0", i, ctrl_writeEnable); end
        end
        idle_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_idle_drain();
        test_full_preempt();
        test_exception_r0();
        test_w_status();
        test_hazard();
        test_starvation();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
